// File: rtl/spi_loader.sv
// -----------------------------------------------------------------------------
// spi_loader
//
// Loads instruction and data memories from a serial master and then hands
// control to the processor.
//
// Each frame carries 12 bits, sent LSB first: a 4-bit address followed by an
// 8-bit data byte. mode_in selects the phase:
//   00 = idle/gap, 01 = instruction load, 10 = data load, 11 = run.
// After a complete frame the block issues a one-cycle write strobe to the
// selected memory. It then waits for mode 00 before it accepts another frame.
// If mode_in changes in the middle of a frame, the frame is dropped and
// frame_err pulses for one cycle.
//
// Optional feature: define SPI_LOADER_SYNC_EN to pass sclk_in, mosi_in and
// mode_in through 2-flop synchronizers. This adds 2 clk of latency.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   sclk_in    serial clock from the loader (free-running, period >= 2 clk)
//   mosi_in    serial data, valid at the sclk_in rising edge
//   mode_in    phase select (see above)
//   halt_in    processor finished; only used in run mode
//   imem_we    one-cycle instruction-memory write strobe
//   dmem_we    one-cycle data-memory write strobe
//   wr_addr    write address (shared), holds the last written value
//   wr_data    write data (shared), holds the last written value
//   done_out   load phase reached address 15, or halt_in while running
//   run_en     processor execute enable
//   frame_err  one-cycle pulse when a frame is aborted
// -----------------------------------------------------------------------------
module spi_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic [1:0] mode_in,
  input  logic       halt_in,
  output logic       imem_we,
  output logic       dmem_we,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done_out,
  output logic       run_en,
  output logic       frame_err
);

  localparam logic [1:0] MODE_GAP  = 2'b00;
  localparam logic [1:0] MODE_IMEM = 2'b01;
  localparam logic [1:0] MODE_DMEM = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_GAP,
    S_RUN
  } state_t;

  // Effective inputs. These are either synchronized or taken directly.
  logic       sclk_e;
  logic       mosi_e;
  logic [1:0] mode_e;

`ifdef SPI_LOADER_SYNC_EN
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] mode_sync0;
  logic [1:0] mode_sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      mode_sync0 <= '0;
      mode_sync1 <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk_in};
      mosi_sync  <= {mosi_sync[0], mosi_in};
      mode_sync0 <= mode_in;
      mode_sync1 <= mode_sync0;
    end
  end

  assign sclk_e = sclk_sync[1];
  assign mosi_e = mosi_sync[1];
  assign mode_e = mode_sync1;
`else
  assign sclk_e = sclk_in;
  assign mosi_e = mosi_in;
  assign mode_e = mode_in;
`endif

  state_t      state;
  state_t      state_d;
  logic        sclk_prev;
  logic        sclk_rise;
  logic [1:0]  frame_mode;   // mode latched at frame start (01 or 10)
  logic [1:0]  last_mode;    // frame mode of the previous load phase
  logic [3:0]  bit_cnt;
  logic [11:0] shift_reg;
  logic [3:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        last_addr_seen;

  logic        start_frame;
  logic        shift_en;
  logic        abort;

  assign sclk_rise = sclk_e & ~sclk_prev;

  // Next-state logic and control strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves any of them unassigned would infer a latch.
    state_d     = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    abort       = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode_e == MODE_IMEM || mode_e == MODE_DMEM) begin
          start_frame = 1'b1;
          state_d     = S_RECV;
        end else if (mode_e == MODE_RUN) begin
          state_d = S_RUN;
        end
      end
      S_RECV: begin
        // A mode change wins over a simultaneous sclk edge. The partial
        // frame is dropped.
        if (mode_e != frame_mode) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd11) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_GAP;
      S_GAP:   if (mode_e == MODE_GAP) state_d = S_IDLE;
      S_RUN:   if (mode_e == MODE_GAP) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments. Every read
    // in this block therefore sees the value from before the clock edge.
    if (rst) begin
      state          <= S_IDLE;
      sclk_prev      <= 1'b0;
      frame_mode     <= MODE_GAP;
      last_mode      <= MODE_GAP;
      bit_cnt        <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      last_addr_seen <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state     <= state_d;
      sclk_prev <= sclk_e;
      frame_err <= abort;
      if (start_frame) begin
        frame_mode <= mode_e;
        last_mode  <= mode_e;
        bit_cnt    <= '0;
        // A new load phase of the other memory type re-arms done_out.
        if (mode_e != last_mode) last_addr_seen <= 1'b0;
      end
      if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (state == S_WRITE) begin
        wr_addr_q <= shift_reg[3:0];
        wr_data_q <= shift_reg[11:4];
        if (shift_reg[3:0] == 4'hF) last_addr_seen <= 1'b1;
      end
    end
  end

  // NOTE: the shift register is pure datapath and has no reset. Its contents
  // are only used in WRITE, and by then all 12 bits have been shifted in.
  always_ff @(posedge clk) begin
    if (shift_en) shift_reg <= {mosi_e, shift_reg[11:1]};
  end

  // During WRITE the fresh frame drives the bus directly. At all other times
  // the bus shows the value of the last completed write.
  assign wr_addr  = (state == S_WRITE) ? shift_reg[3:0]  : wr_addr_q;
  assign wr_data  = (state == S_WRITE) ? shift_reg[11:4] : wr_data_q;
  assign imem_we  = (state == S_WRITE) && (frame_mode == MODE_IMEM);
  assign dmem_we  = (state == S_WRITE) && (frame_mode == MODE_DMEM);
  assign run_en   = (state == S_RUN);
  assign done_out = run_en ? halt_in : last_addr_seen;

endmodule
